gt_rst_seq: RTL and testbench
=============================

# gt_rst_seq

Reset sequencer for the GT PHY: consumes the system reset and the GT status flags, and drives the GT-side reset outputs in a fixed order. The order is hold the GT in reset, wait for PLL lock, release TX/RX datapath resets, then wait for both reset-done flags. Sits between the board-level reset source and the GT wrapper. Its `o_phy_ready` gates all user-side GT traffic.

## Interface
Parameters:
- `P_HOLD_CYCLE`, 10: cycles `o_gt_rst` stays asserted on each entry to HOLD; legal range 1..65535.
- `P_TIMEOUT`, 50000: watchdog limit in cycles for WAIT_LOCK and WAIT_DONE; legal range 1..2^24-1.
- `P_SYNC_STAGES`, 2: flop stages on each asynchronous GT status input; minimum 2.

Ports:
- `i_clk` input 1: free-running sequencer clock; must run while the GT is in reset.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_pll_lock` input 1: GT PLL lock; asynchronous to `i_clk`.
- `i_tx_rst_done` input 1: GT TX reset done; asynchronous.
- `i_rx_rst_done` input 1: GT RX reset done; asynchronous.
- `o_gt_rst` output 1: GT PLL/global reset, active-high.
- `o_tx_rst` output 1: GT TX datapath reset, active-high.
- `o_rx_rst` output 1: GT RX datapath reset, active-high.
- `o_phy_ready` output 1: high while the PHY is fully out of reset.
- `o_retry_cnt` output 8: number of restarts caused by watchdog timeouts or lock loss; saturating.

## Operation
- Each status input passes through a `P_SYNC_STAGES` synchronizer. All decisions use the synchronized versions: `lock_s`, `txd_s`, `rxd_s`.
- **Reset values:** `o_gt_rst`=1, `o_tx_rst`=1, `o_rx_rst`=1, `o_phy_ready`=0, `o_retry_cnt`=0. State is HOLD with hold counter 0. Watchdog counter is 0. Synchronizer flops are 0.
- **HOLD**
  - Outputs: `o_gt_rst`=1, `o_tx_rst`=1, `o_rx_rst`=1, `o_phy_ready`=0.
  - The hold counter increments each cycle.
  - When it reaches `P_HOLD_CYCLE`-1, go to WAIT_LOCK.
- **WAIT_LOCK**
  - Outputs: `o_gt_rst`=0; TX/RX resets remain 1.
  - `lock_s`=1: go to WAIT_DONE.
- **WAIT_DONE**
  - Outputs: `o_gt_rst`=0, `o_tx_rst`=0, `o_rx_rst`=0.
  - `txd_s`=1 and `rxd_s`=1 in the same cycle: go to READY.
  - `lock_s`=0: go to HOLD as a lock-loss restart.
- **READY**
  - Outputs: `o_phy_ready`=1; all resets 0.
  - `lock_s`=0, `txd_s`=0 or `rxd_s`=0: go to HOLD as a restart.
- **Restart effects:** every transition into HOLD from any state other than HOLD itself:
  - clears the hold counter and the watchdog;
  - increments `o_retry_cnt`, saturating at 255.
- **Watchdog:** cleared on every state change; counts while in WAIT_LOCK or WAIT_DONE.
- **Simultaneous events:**
  - A timeout and a lock loss in the same cycle count as one restart (+1).
  - Lock loss in WAIT_DONE takes priority over both dones being seen in the same cycle.
- **Mid-operation `i_rst`:** immediately forces the reset values in any state, including READY. `o_retry_cnt` is cleared.

## Timing
- All outputs are registered, and each output depends only on the current state.
- After `i_rst` deasserts, `o_gt_rst` stays high for exactly `P_HOLD_CYCLE` rising edges, then falls.
- Input-to-decision latency is `P_SYNC_STAGES` cycles. The state updates on the following edge.
  - Example: with 2 stages, `o_tx_rst`/`o_rx_rst` fall 3 edges after `i_pll_lock` rises, given the design is in WAIT_LOCK.
- `o_phy_ready` rises `P_SYNC_STAGES`+1 edges after the later of the two done flags rises.
- A status glitch shorter than one `i_clk` period may be missed; this is acceptable.

## Configuration
- **`GT_RST_WATCHDOG_EN` defined:**
  - Watchdog counter is present.
  - When the watchdog reaches `P_TIMEOUT`-1 in WAIT_LOCK or WAIT_DONE, the next state is HOLD and the restart counts.
- **Not defined:**
  - No watchdog logic.
  - WAIT_LOCK and WAIT_DONE wait indefinitely.
  - `o_retry_cnt` counts lock/done-loss restarts only.

## Structure
- Package `gt_rst_pkg` holds:
  - the state enum (HOLD, WAIT_LOCK, WAIT_DONE, READY) as a 2-bit encoding;
  - `HOLD_W` = 16 and `WDOG_W` = 24;
  - `RETRY_MAX` = 8'd255.
- Sub-module `sync_bit`: a parameterized multi-flop synchronizer with depth `P_SYNC_STAGES`, reset to 0. It is instantiated three times, once per status input.

## Test plan
Settings for all scenarios: `P_HOLD_CYCLE`=10, `P_TIMEOUT`=100, `P_SYNC_STAGES`=2, `GT_RST_WATCHDOG_EN` defined.
- **Nominal bring-up:** release `i_rst`, raise lock at cycle 20, raise both dones at cycle 40.
  - `o_gt_rst` falls at edge 10.
  - TX/RX resets fall at edge 23.
  - `o_phy_ready` rises at edge 43.
  - `o_retry_cnt`=0.
- **Lock never asserts:** HOLD→WAIT_LOCK, then after 100 cycles back to HOLD.
  - `o_retry_cnt` steps 1, 2, 3 at each timeout.
  - `o_gt_rst` reasserts for 10 cycles each time.
- **Lock drop in READY:** all outputs return to HOLD values 3 edges after the drop; `o_retry_cnt`=1.
- **Only TX done asserts:** `o_phy_ready` stays 0; a timeout in WAIT_DONE returns the design to HOLD.
- **Async `i_rst` pulse mid-READY:** outputs take reset values without waiting for a clock edge; `o_retry_cnt`=0.
- **Saturation:** with lock held low for 300 restarts, `o_retry_cnt` holds at 255.

Source files
------------

// File: rtl/gt_rst_pkg.sv
// Shared types and constants for the GT PHY reset sequencer.
package gt_rst_pkg;

  localparam int unsigned HOLD_W    = 16;
  localparam int unsigned WDOG_W    = 24;
  localparam logic [7:0]  RETRY_MAX = 8'd255;

  typedef enum logic [1:0] {
    StHold     = 2'd0,
    StWaitLock = 2'd1,
    StWaitDone = 2'd2,
    StReady    = 2'd3
  } gt_state_e;

  typedef struct packed {
    logic gt_rst;
    logic tx_rst;
    logic rx_rst;
    logic phy_ready;
  } gt_out_t;

  function automatic gt_out_t state_outputs(gt_state_e st);
    gt_out_t o;
    o.gt_rst    = (st == StHold);
    o.tx_rst    = (st == StHold) || (st == StWaitLock);
    o.rx_rst    = (st == StHold) || (st == StWaitLock);
    o.phy_ready = (st == StReady);
    return o;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; all stages reset to 0.
module sync_bit #(
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [P_SYNC_STAGES-1:0] sync_q;
  logic [P_SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[P_SYNC_STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[P_SYNC_STAGES-1];

endmodule

// File: rtl/gt_rst_seq.sv
// GT PHY reset sequencer: HOLD -> WAIT_LOCK -> WAIT_DONE -> READY with restart counting.
// Define GT_RST_WATCHDOG_EN to add the WAIT_LOCK/WAIT_DONE timeout watchdog.
module gt_rst_seq
  import gt_rst_pkg::*;
#(
  parameter int unsigned P_HOLD_CYCLE  = 10,
  parameter int unsigned P_TIMEOUT     = 50000,
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_lock,
  input  logic       i_tx_rst_done,
  input  logic       i_rx_rst_done,
  output logic       o_gt_rst,
  output logic       o_tx_rst,
  output logic       o_rx_rst,
  output logic       o_phy_ready,
  output logic [7:0] o_retry_cnt
);

  logic lock_s, txd_s, rxd_s;

  sync_bit #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync_lock (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_pll_lock), .o_q(lock_s)
  );
  sync_bit #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync_txd (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_tx_rst_done), .o_q(txd_s)
  );
  sync_bit #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync_rxd (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_rx_rst_done), .o_q(rxd_s)
  );

  gt_state_e         state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]        retry_cnt_q, retry_cnt_d;
  gt_out_t           out_q, out_d;
  logic              restart;
  logic              timeout;

`ifdef GT_RST_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  assign timeout = ((state_q == StWaitLock) || (state_q == StWaitDone)) &&
                   (wdog_q == WDOG_W'(P_TIMEOUT - 1));

  always_comb begin
    wdog_d = '0;
    if ((state_d == state_q) && ((state_q == StWaitLock) || (state_q == StWaitDone))) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = ^WDOG_W'(P_TIMEOUT);
`endif

  // A timeout wins over forward progress; lock loss and timeout together are one restart.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == HOLD_W'(P_HOLD_CYCLE - 1)) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (timeout)     restart = 1'b1;
        else if (lock_s) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!lock_s || timeout)  restart = 1'b1;
        else if (txd_s && rxd_s) state_d = StReady;
      end
      StReady: begin
        if (!(lock_s && txd_s && rxd_s)) restart = 1'b1;
      end
      default: state_d = StHold;
    endcase
    if (restart) state_d = StHold;
  end

  always_comb begin
    hold_cnt_d = '0;
    if ((state_q == StHold) && (state_d == StHold)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end

    retry_cnt_d = retry_cnt_q;
    if (restart && (retry_cnt_q != RETRY_MAX)) begin
      retry_cnt_d = retry_cnt_q + 8'd1;
    end

    // Outputs are registered from the next state so they always match state_q.
    out_d = state_outputs(state_d);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      retry_cnt_q <= '0;
      out_q       <= state_outputs(StHold);
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      out_q       <= out_d;
    end
  end

  assign o_gt_rst    = out_q.gt_rst;
  assign o_tx_rst    = out_q.tx_rst;
  assign o_rx_rst    = out_q.rx_rst;
  assign o_phy_ready = out_q.phy_ready;
  assign o_retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_gt_rst_seq.sv
// Self-checking bench for gt_rst_seq: directed bring-up/restart scenarios plus random status
// stimulus compared cycle by cycle against a phase/age reference model.
module tb_gt_rst_seq;

  localparam int HoldCycles = 10;
  localparam int Timeout    = 100;
  localparam int SyncStages = 2;
`ifdef GT_RST_WATCHDOG_EN
  localparam bit WdogEn = 1'b1;
`else
  localparam bit WdogEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock = 1'b0, txd = 1'b0, rxd = 1'b0;
  logic       gt_rst, tx_rst, rx_rst, phy_ready;
  logic [7:0] retry_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          edge_n   = 0;

  always #5 clk = ~clk;

  gt_rst_seq #(
    .P_HOLD_CYCLE (HoldCycles),
    .P_TIMEOUT    (Timeout),
    .P_SYNC_STAGES(SyncStages)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pll_lock   (lock),
    .i_tx_rst_done(txd),
    .i_rx_rst_done(rxd),
    .o_gt_rst     (gt_rst),
    .o_tx_rst     (tx_rst),
    .o_rx_rst     (rx_rst),
    .o_phy_ready  (phy_ready),
    .o_retry_cnt  (retry_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a phase, time spent in it, and the input seen SyncStages edges ago.
  localparam int PhHold = 0, PhLock = 1, PhDone = 2, PhReady = 3;
  int m_phase, m_age, m_retries;
  bit hist_lock[$], hist_tx[$], hist_rx[$];

  function automatic void model_reset();
    m_phase = PhHold; m_age = 0; m_retries = 0;
    hist_lock = {}; hist_tx = {}; hist_rx = {};
    for (int i = 0; i < SyncStages; i++) begin
      hist_lock.push_back(1'b0); hist_tx.push_back(1'b0); hist_rx.push_back(1'b0);
    end
  endfunction

  function automatic void model_step();
    bit ls, ts, rs, expired, restart;
    int nxt;
    ls = hist_lock.pop_front(); ts = hist_tx.pop_front(); rs = hist_rx.pop_front();
    hist_lock.push_back(lock); hist_tx.push_back(txd); hist_rx.push_back(rxd);
    expired = WdogEn && (m_phase == PhLock || m_phase == PhDone) && (m_age == Timeout - 1);
    nxt = m_phase;
    restart = 1'b0;
    case (m_phase)
      PhHold:  if (m_age == HoldCycles - 1) nxt = PhLock;
      PhLock:  if (expired) restart = 1'b1; else if (ls) nxt = PhDone;
      PhDone:  if (!ls || expired) restart = 1'b1; else if (ts && rs) nxt = PhReady;
      default: if (!(ls && ts && rs)) restart = 1'b1;
    endcase
    if (restart) begin
      nxt = PhHold;
      if (m_retries < 255) m_retries++;
    end
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
  endfunction

  function automatic logic [11:0] model_vec();
    logic g, t, y;
    g = (m_phase == PhHold);
    t = (m_phase == PhHold) || (m_phase == PhLock);
    y = (m_phase == PhReady);
    return {g, t, t, y, 8'(m_retries)};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {gt_rst, tx_rst, rx_rst, phy_ready, retry_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    edge_n++;
    #1;
    check_eq($sformatf("cycle_e%0d", edge_n), 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic run_until(input int e);
    while (edge_n < e) tick();
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq(tag, 32'(dut_vec()), 32'({4'b1110, 8'd0}));
    lock = 1'b0; txd = 1'b0; rxd = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish, expected finish within 2 ms");
    $fatal(1);
  end

  initial begin
    // Nominal bring-up
    apply_reset("reset_vals");
    run_until(9);
    check_eq("gt_rst_e9", 32'(gt_rst), 32'd1);
    run_until(10);
    check_eq("gt_rst_e10", 32'(gt_rst), 32'd0);
    run_until(20);
    lock = 1'b1;
    run_until(22);
    check_eq("txrx_rst_e22", 32'({tx_rst, rx_rst}), 32'd3);
    run_until(23);
    check_eq("txrx_rst_e23", 32'({tx_rst, rx_rst}), 32'd0);
    run_until(40);
    txd = 1'b1; rxd = 1'b1;
    run_until(42);
    check_eq("ready_e42", 32'(phy_ready), 32'd0);
    run_until(43);
    check_eq("ready_e43", 32'(phy_ready), 32'd1);
    check_eq("retry_nominal", 32'(retry_cnt), 32'd0);

    // Lock drop in READY
    run_until(50);
    lock = 1'b0;
    run_until(52);
    check_eq("ready_before_drop", 32'(phy_ready), 32'd1);
    run_until(53);
    check_eq("hold_after_drop", 32'({gt_rst, tx_rst, rx_rst, phy_ready}), 32'b1110);
    check_eq("retry_after_drop", 32'(retry_cnt), 32'd1);

    // Async reset pulse mid-READY clears the retry count
    lock = 1'b1;
    run_until(80);
    check_eq("ready_again", 32'(phy_ready), 32'd1);
    apply_reset("async_rst_ready");

    // Lock never asserts
    run_until(110);
    check_eq("nolock_retry1", 32'(retry_cnt), 32'(WdogEn));
    check_eq("nolock_gt_e110", 32'(gt_rst), 32'(WdogEn));
    run_until(119);
    check_eq("nolock_gt_e119", 32'(gt_rst), 32'(WdogEn));
    run_until(120);
    check_eq("nolock_gt_e120", 32'(gt_rst), 32'd0);
    run_until(220);
    check_eq("nolock_retry2", 32'(retry_cnt), WdogEn ? 32'd2 : 32'd0);
    run_until(330);
    check_eq("nolock_retry3", 32'(retry_cnt), WdogEn ? 32'd3 : 32'd0);

    // Only TX done
    apply_reset("reset_txonly");
    lock = 1'b1; txd = 1'b1;
    run_until(110);
    check_eq("txonly_not_ready", 32'(phy_ready), 32'd0);
    check_eq("txonly_txrst_low", 32'(tx_rst), 32'd0);
    run_until(111);
    check_eq("txonly_gt_e111", 32'(gt_rst), 32'(WdogEn));
    check_eq("txonly_retry", 32'(retry_cnt), 32'(WdogEn));

    // Random status activity
    apply_reset("reset_random");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) lock = ~lock;
      if ($urandom_range(0, 29) == 0) txd = ~txd;
      if ($urandom_range(0, 29) == 0) rxd = ~rxd;
      tick();
    end

    // Saturation via repeated lock-loss restarts
    apply_reset("reset_sat");
    for (int k = 0; k < 300; k++) begin
      lock = 1'b1;
      repeat ($urandom_range(20, 40)) tick();
      lock = 1'b0;
      repeat ($urandom_range(3, 8)) tick();
    end
    check_eq("retry_saturated", 32'(retry_cnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
